toggle_cover_detector: RTL



---
 rtl/toggle_cover_pkg.sv | 20 ++
 rtl/toggle_pri_enc.sv | 26 ++
 rtl/toggle_cover_detector.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle cover detector slice.
// Event numbering: each monitored bit owns two adjacent local events,
// rise first, then fall.
package toggle_cover_pkg;

  // Width of a global cover index; matches the longint of the cover hook.
  localparam int IDX_W = 64;

  // Transition direction, used as the low bit of a local event number.
  typedef enum logic {
    DIR_RISE = 1'b0,
    DIR_FALL = 1'b1
  } dir_e;

  // Local event number of bit b toggling in direction dir.
  function automatic int ev_local(input int b, input dir_e dir);
    return 2 * b + int'(dir);
  endfunction

endpackage

// File: rtl/toggle_pri_enc.sv
// Lowest-set-bit encoder. It picks which pending cover event is reported
// next, so lower event numbers always drain first.
module toggle_pri_enc #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the top down so that the last hit, the lowest set bit, wins.
  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/toggle_cover_detector.sv
// Toggle cover detector: watches a WIDTH-bit signal, records each rise and
// fall as a cover event, and streams new events as global cover indices
// over a valid/ready interface, lowest event first.
// Optional build macro COVER_REPORT_ALL_EN: report every detected toggle,
// not just the first occurrence of each event.
module toggle_cover_detector
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COVER_BASE  = 0,
  parameter int COVER_TOTAL = 8065
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [WIDTH-1:0]               sig,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_index,
  output logic [$clog2(2*WIDTH+1)-1:0]   hit_count,
  output logic                           all_covered
);

  localparam int NEV  = 2 * WIDTH;
  localparam int EW   = (NEV > 1) ? $clog2(NEV) : 1;
  localparam int HC_W = $clog2(NEV + 1);

  // Refuse to build an instance whose events overrun the global cover space.
  if (COVER_BASE + NEV > COVER_TOTAL) begin : g_bad_cover_range
    $error("toggle_cover_detector: COVER_BASE + 2*WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  logic [NEV-1:0]   pending;
  logic [NEV-1:0]   covered;
  logic [EW-1:0]    out_local;

  logic [NEV-1:0]   det;
  logic [NEV-1:0]   set_vec;
  logic [NEV-1:0]   clr_mask;
  logic [NEV-1:0]   pending_nxt;
  logic [NEV-1:0]   covered_nxt;
  logic [HC_W-1:0]  hit_nxt;
  logic             held;
  logic             load;
  logic             pend_found;
  logic [EW-1:0]    pend_idx;

  function automatic logic [HC_W-1:0] popcount(input logic [NEV-1:0] v);
    logic [HC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NEV; i++) n = n + HC_W'(v[i]);
    return n;
  endfunction

  // Edge detection against the previous sample; gated until a valid sample exists.
  always_comb begin
    det = '0;
    if (enable && prev_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        det[ev_local(i, DIR_RISE)] = ~prev[i] & sig[i];
        det[ev_local(i, DIR_FALL)] = prev[i] & ~sig[i];
      end
    end
  end

  // The output register is free to take a new event unless it is stalled.
  assign held = out_valid && !out_ready;
  assign load = !held;

`ifdef COVER_REPORT_ALL_EN
  logic [NEV-1:0] hold_mask;

  // A re-detected event already sitting stalled in the output folds into that report.
  always_comb begin
    hold_mask = '0;
    if (held) hold_mask[out_local] = 1'b1;
  end

  assign set_vec = det & ~hold_mask;
`else
  assign set_vec = det & ~covered;
`endif

  toggle_pri_enc #(
    .N  (NEV),
    .IW (EW)
  ) u_pri_enc (
    .vec   (pending),
    .found (pend_found),
    .idx   (pend_idx)
  );

  // Clear the event being moved into the output register.
  always_comb begin
    clr_mask = '0;
    if (load && pend_found) clr_mask[pend_idx] = 1'b1;
  end

  // A set arriving on the same bit as the clear keeps the bit pending.
  assign pending_nxt = (pending & ~clr_mask) | set_vec;
  assign covered_nxt = covered | det;
  assign hit_nxt     = popcount(covered_nxt);

  // Sample history, event bitmaps and counters.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clock) begin
    // NOTE: the bitmaps are plain flops, not RAM, so they are cleared by reset
    // along with the rest; a reset must drop every queued event.
    if (reset) begin
      prev        <= '0;
      prev_valid  <= 1'b0;
      pending     <= '0;
      covered     <= '0;
      hit_count   <= '0;
      all_covered <= 1'b0;
    end else begin
      prev        <= sig;
      prev_valid  <= 1'b1;
      pending     <= pending_nxt;
      covered     <= covered_nxt;
      hit_count   <= hit_nxt;
      all_covered <= (hit_nxt == HC_W'(NEV));
    end
  end

  // Output register: loads the lowest pending event whenever it is not stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_local <= '0;
      out_index <= '0;
    end else if (load) begin
      out_valid <= pend_found;
      if (pend_found) begin
        out_local <= pend_idx;
        out_index <= IDX_W'(COVER_BASE) + IDX_W'(pend_idx);
      end
    end
  end

endmodule
